// File: rtl/multdiv_sequencer_if.sv
// Execute-stage handshake for the multi-cycle mul/div engine.
// master = execute-stage control, slave = the engine itself.
interface multdiv_sequencer_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  start;
  logic                  is_div;
  logic [DATA_WIDTH-1:0] operandA;
  logic [DATA_WIDTH-1:0] operandB;
  logic [4:0]            dest_reg;
  logic                  flush;
  logic                  stall;
  logic                  busy;
  logic                  result_valid;
  logic [DATA_WIDTH-1:0] result;
  logic                  exception;
  logic [31:0]           exc_code;
  logic [4:0]            result_dest;

  modport master (
    output start, is_div, operandA, operandB, dest_reg, flush,
    input  stall, busy, result_valid, result, exception, exc_code, result_dest
  );

  modport slave (
    input  start, is_div, operandA, operandB, dest_reg, flush,
    output stall, busy, result_valid, result, exception, exc_code, result_dest
  );
endinterface

// File: rtl/multdiv_sequencer.sv
// Multi-cycle signed multiply (radix-2 Booth) / divide (restoring) engine
// with the IDLE/BUSY/DONE controller that stalls the front of the pipe.
module multdiv_sequencer #(
  parameter int DATA_WIDTH   = 32,
  parameter int EXC_CODE_MUL = 4,
  parameter int EXC_CODE_DIV = 5
) (
  input  logic               clock,
  input  logic               reset,
  multdiv_sequencer_if.slave bus
);
  localparam int             CW   = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(DATA_WIDTH - 1);
  localparam int             MSB  = DATA_WIDTH - 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                state_reg, state_next;
  logic [CW-1:0]         count_reg, count_next;
  // acc is one bit wider than the operands so Booth add/sub of -2^31 cannot wrap
  logic [DATA_WIDTH:0]   acc_reg, acc_next;
  logic [DATA_WIDTH-1:0] mq_reg, mq_next;   // multiplier / dividend-then-quotient
  logic [DATA_WIDTH-1:0] m_reg, m_next;     // multiplicand / |divisor|
  logic                  q1_reg, q1_next;
  logic                  is_div_reg, is_div_next;
  logic                  neg_reg, neg_next;
  logic [DATA_WIDTH-1:0] result_reg, result_next;
  logic                  exception_reg, exception_next;
  logic [31:0]           exc_code_reg, exc_code_next;
  logic [4:0]            result_dest_reg, result_dest_next;

  logic [DATA_WIDTH:0]   booth_sum, booth_acc, div_shift, div_diff, div_acc;
  logic [DATA_WIDTH-1:0] booth_mq, div_mq, quotient, abs_a, abs_b;
  logic                  div_fits, mul_ovf, div_ovf, accept, div_by_zero;

  // One iteration of each algorithm, plus operand magnitudes for a new divide
  always_comb begin
    booth_sum = acc_reg;
    case ({mq_reg[0], q1_reg})
      2'b01:   booth_sum = acc_reg + {m_reg[MSB], m_reg};
      2'b10:   booth_sum = acc_reg - {m_reg[MSB], m_reg};
      default: booth_sum = acc_reg;
    endcase
    booth_acc = {booth_sum[DATA_WIDTH], booth_sum[DATA_WIDTH:1]};
    booth_mq  = {booth_sum[0], mq_reg[MSB:1]};
    // product high half must be pure sign extension of the low half
    mul_ovf   = booth_acc[MSB:0] != {DATA_WIDTH{booth_mq[MSB]}};

    div_shift = {acc_reg[MSB:0], mq_reg[MSB]};
    div_diff  = div_shift - {1'b0, m_reg};
    div_fits  = ~div_diff[DATA_WIDTH];
    div_acc   = div_fits ? div_diff : div_shift;
    div_mq    = {mq_reg[MSB-1:0], div_fits};
    quotient  = neg_reg ? -div_mq : div_mq;
    // only |-2^31 / -1| = 2^31 lands in the sign bit of a positive quotient
    div_ovf   = div_mq[MSB] & ~neg_reg;

    abs_a       = bus.operandA[MSB] ? -bus.operandA : bus.operandA;
    abs_b       = bus.operandB[MSB] ? -bus.operandB : bus.operandB;
    accept      = (state_reg == IDLE) & bus.start & ~bus.flush;
    div_by_zero = bus.is_div & (bus.operandB == '0);
  end

  // Next-state and register-load decisions; flush overrides every transition
  always_comb begin
    state_next       = state_reg;
    count_next       = count_reg;
    acc_next         = acc_reg;
    mq_next          = mq_reg;
    m_next           = m_reg;
    q1_next          = q1_reg;
    is_div_next      = is_div_reg;
    neg_next         = neg_reg;
    result_next      = result_reg;
    exception_next   = exception_reg;
    exc_code_next    = exc_code_reg;
    result_dest_next = result_dest_reg;

    unique case (state_reg)
      IDLE: begin
        if (accept) begin
          is_div_next      = bus.is_div;
          result_dest_next = bus.dest_reg;
          count_next       = '0;
          acc_next         = '0;
          q1_next          = 1'b0;
          result_next      = '0;
          exception_next   = 1'b0;
          exc_code_next    = '0;
          if (bus.is_div) begin
            mq_next  = abs_a;
            m_next   = abs_b;
            neg_next = bus.operandA[MSB] ^ bus.operandB[MSB];
          end else begin
            mq_next  = bus.operandB;
            m_next   = bus.operandA;
            neg_next = 1'b0;
          end
          if (div_by_zero) begin
            state_next     = DONE;
            exception_next = 1'b1;
            exc_code_next  = EXC_CODE_DIV;
          end else begin
            state_next = BUSY;
          end
        end
      end
      BUSY: begin
        acc_next   = is_div_reg ? div_acc : booth_acc;
        mq_next    = is_div_reg ? div_mq : booth_mq;
        q1_next    = is_div_reg ? 1'b0 : mq_reg[0];
        count_next = count_reg + CW'(1);
        if (count_reg == LAST) begin
          state_next = DONE;
          count_next = '0;
          if (is_div_reg) begin
            result_next    = quotient;
            exception_next = div_ovf;
            exc_code_next  = div_ovf ? EXC_CODE_DIV : 0;
          end else begin
            result_next    = booth_mq;
            exception_next = mul_ovf;
            exc_code_next  = mul_ovf ? EXC_CODE_MUL : 0;
          end
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase

    if (bus.flush) begin
      state_next       = IDLE;
      count_next       = '0;
      result_next      = '0;
      exception_next   = 1'b0;
      exc_code_next    = '0;
      result_dest_next = '0;
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg       <= IDLE;
      count_reg       <= '0;
      acc_reg         <= '0;
      mq_reg          <= '0;
      m_reg           <= '0;
      q1_reg          <= 1'b0;
      is_div_reg      <= 1'b0;
      neg_reg         <= 1'b0;
      result_reg      <= '0;
      exception_reg   <= 1'b0;
      exc_code_reg    <= '0;
      result_dest_reg <= '0;
    end else begin
      state_reg       <= state_next;
      count_reg       <= count_next;
      acc_reg         <= acc_next;
      mq_reg          <= mq_next;
      m_reg           <= m_next;
      q1_reg          <= q1_next;
      is_div_reg      <= is_div_next;
      neg_reg         <= neg_next;
      result_reg      <= result_next;
      exception_reg   <= exception_next;
      exc_code_reg    <= exc_code_next;
      result_dest_reg <= result_dest_next;
    end
  end

  assign bus.stall        = accept | (state_reg == BUSY);
  assign bus.busy         = (state_reg == BUSY);
  assign bus.result_valid = (state_reg == DONE) & ~bus.flush;
  assign bus.result       = result_reg;
  assign bus.exception    = exception_reg;
  assign bus.exc_code     = exc_code_reg;
  assign bus.result_dest  = result_dest_reg;
endmodule

// File: tb/tb_multdiv_sequencer.sv
// Scoreboard bench: stimulus pushes reference results, a monitor pops them on result_valid.
module tb_multdiv_sequencer;
  localparam int DW = 32;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  multdiv_sequencer_if #(.DATA_WIDTH(DW)) bus();

  multdiv_sequencer #(
    .DATA_WIDTH(DW), .EXC_CODE_MUL(4), .EXC_CODE_DIV(5)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  typedef struct {
    logic [31:0] res;
    logic        exc;
    logic [31:0] code;
    logic [4:0]  rd;
    int          at;
  } exp_t;

  exp_t sb_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain signed arithmetic on 64-bit integers
  function automatic exp_t model(input bit d, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] rd, input int t);
    exp_t   e;
    longint p;
    logic [31:0] q;
    e.rd = rd;
    if (!d) begin
      p     = longint'($signed(a)) * longint'($signed(b));
      e.res = p[31:0];
      e.exc = (p != longint'($signed(p[31:0])));
      e.code = e.exc ? 32'd4 : 32'd0;
      e.at  = t + 33;
    end else if (b == 32'd0) begin
      e.res = 32'd0; e.exc = 1'b1; e.code = 32'd5; e.at = t + 1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.res = 32'h8000_0000; e.exc = 1'b1; e.code = 32'd5; e.at = t + 33;
    end else begin
      q     = $signed(a) / $signed(b);
      e.res = q; e.exc = 1'b0; e.code = 32'd0; e.at = t + 33;
    end
    return e;
  endfunction

  // Monitor: every result_valid must match the oldest outstanding expectation
  always @(negedge clock) begin
    exp_t e;
    if (bus.result_valid === 1'b1) begin
      $display("txn cyc=%0d result=%08h exc=%0b code=%0d rd=%0d",
               cyc, bus.result, bus.exception, bus.exc_code, bus.result_dest);
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid: got result_valid=1 required 0 (cycle %0d)", cyc);
      end else begin
        e = sb_q.pop_front();
        check("valid_cycle", cyc, e.at);
        check("result", bus.result, e.res);
        check("exception", bus.exception, e.exc);
        check("exc_code", bus.exc_code, e.code);
        check("result_dest", bus.result_dest, e.rd);
      end
    end
  end

  // Issue one op; returns in the DONE cycle (#1 after its falling edge)
  task automatic run_op(input bit d, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input bit hold);
    int t0, stalls;
    bit done, dz;
    @(negedge clock); #1;
    bus.start = 1'b1; bus.is_div = d; bus.operandA = a; bus.operandB = b; bus.dest_reg = rd;
    t0 = cyc;
    dz = d && (b == 32'd0);
    sb_q.push_back(model(d, a, b, rd, t0));
    #1;
    stalls = bus.stall ? 1 : 0;
    done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clock); #1;
      if (!hold) bus.start = 1'b0;
      if (sb_q.size() == 0) begin
        done = 1'b1;
        check("stall_in_done", bus.stall, 0);
      end else if (bus.stall) begin
        stalls++;
      end
    end
    check("op_completed", done, 1);
    if (!done) sb_q.delete();
    check("stall_cycles", stalls, dz ? 1 : 33);
  endtask

  function automatic logic [31:0] pick(input int mode);
    logic [31:0] v;
    case (mode)
      0: v = $urandom;
      1: v = $urandom_range(0, 200) - 100;
      2: begin
        case ($urandom_range(0, 3))
          0: v = 32'h8000_0000;
          1: v = 32'hFFFF_FFFF;
          2: v = 32'h7FFF_FFFF;
          default: v = 32'd1;
        endcase
      end
      default: v = $urandom_range(0, 65535);
    endcase
    return v;
  endfunction

  bit          dir_d[8] = '{0, 0, 1, 1, 1, 0, 1, 1};
  logic [31:0] dir_a[8] = '{32'h0001_0000, 32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'h8000_0000,
                            32'd9, 32'h8000_0000, 32'h8000_0000, 32'd100};
  logic [31:0] dir_b[8] = '{32'h0001_0000, 32'd5, 32'd2, 32'hFFFF_FFFF,
                            32'd0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFF9};

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    bus.start = 1'b0; bus.is_div = 1'b0; bus.operandA = '0; bus.operandB = '0;
    bus.dest_reg = '0; bus.flush = 1'b0;

    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock); #1;
    reset = 1'b0;
    #1;
    check("rst_busy", bus.busy, 0);
    check("rst_stall", bus.stall, 0);
    check("rst_valid", bus.result_valid, 0);
    check("rst_result", bus.result, 0);
    check("rst_exception", bus.exception, 0);
    check("rst_exc_code", bus.exc_code, 0);
    check("rst_result_dest", bus.result_dest, 0);

    // Basic multiply, then outputs hold in the following IDLE cycle
    run_op(1'b0, 32'd7, 32'd6, 5'd3, 1'b0);
    @(negedge clock); #1;
    check("hold_result", bus.result, 42);
    check("hold_dest", bus.result_dest, 3);
    check("hold_busy", bus.busy, 0);

    // Directed corner cases, issued back to back
    for (int i = 0; i < 8; i++) run_op(dir_d[i], dir_a[i], dir_b[i], 5'(i + 10), 1'b0);

    // start held through DONE: not relaunched in DONE, only seen again in IDLE
    run_op(1'b0, 32'd100, 32'hFFFF_FFFE, 5'd7, 1'b1);
    @(negedge clock); #1;
    check("done_no_relaunch", bus.busy, 0);
    check("idle_start_stall", bus.stall, 1);
    bus.start = 1'b0;
    #1;
    check("idle_drop_stall", bus.stall, 0);
    @(negedge clock); #1;
    check("idle_drop_busy", bus.busy, 0);

    // Flush mid-op at T+10, new op at T+12
    @(negedge clock); #1;
    bus.start = 1'b1; bus.is_div = 1'b0; bus.operandA = 32'd11; bus.operandB = 32'd13; bus.dest_reg = 5'd4;
    t0 = cyc;
    @(negedge clock); #1;
    bus.start = 1'b0;
    while (cyc < t0 + 10) begin @(negedge clock); #1; end
    bus.flush = 1'b1;
    @(negedge clock); #1;
    bus.flush = 1'b0;
    check("flush_busy", bus.busy, 0);
    check("flush_stall", bus.stall, 0);
    check("flush_dest", bus.result_dest, 0);
    run_op(1'b0, 32'd3, 32'd3, 5'd5, 1'b0);

    // Flush in IDLE with start: not accepted
    @(negedge clock); #1;
    bus.start = 1'b1; bus.flush = 1'b1; bus.is_div = 1'b0;
    #1;
    check("idle_flush_stall", bus.stall, 0);
    @(negedge clock); #1;
    bus.start = 1'b0; bus.flush = 1'b0;
    check("idle_flush_busy", bus.busy, 0);

    // Reset mid-op at T+5
    @(negedge clock); #1;
    bus.start = 1'b1; bus.is_div = 1'b0; bus.operandA = 32'd5; bus.operandB = 32'd5; bus.dest_reg = 5'd9;
    t0 = cyc;
    @(negedge clock); #1;
    bus.start = 1'b0;
    check("midop_busy", bus.busy, 1);
    while (cyc < t0 + 5) begin @(negedge clock); #1; end
    reset = 1'b1;
    @(negedge clock); #1;
    reset = 1'b0;
    #1;
    check("mrst_busy", bus.busy, 0);
    check("mrst_stall", bus.stall, 0);
    check("mrst_result", bus.result, 0);
    check("mrst_dest", bus.result_dest, 0);
    check("mrst_exception", bus.exception, 0);

    // Randomized ops
    for (int i = 0; i < 20; i++) begin
      bit          d;
      logic [31:0] a, b;
      d = 1'($urandom_range(0, 1));
      a = pick($urandom_range(0, 3));
      b = (d && $urandom_range(0, 9) == 0) ? 32'd0 : pick($urandom_range(0, 3));
      run_op(d, a, b, 5'($urandom_range(0, 31)), 1'b0);
    end

    repeat (5) @(negedge clock);
    check("scoreboard_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
